nonce_dispatcher: RTL and testbench
===================================

# nonce_dispatcher

Host-side driver for the SHA-256 miner core: it is the transmitter for the miner's header/nonce input and the receiver for its hash-success output. The host writes a 640-bit block header plus an end nonce as 32-bit words. The dispatcher then sweeps nonces from the header's nonce field up to the end nonce, restarting the miner for each attempt, and returns the first winning nonce and hash through a valid/ready result port. It sits between the host word bus and the miner core.

## Interface
- ATTEMPT_CYCLES, 198, cycles the miner needs per nonce (3 passes × 66), counted after the miner reset pulse.
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- wr_valid  in  1  host word valid.
- wr_data  in  32  host word.
- wr_ready  out  1  word accepted when wr_valid & wr_ready.
- start  in  1  begin sweep (level or pulse, sampled in IDLE).
- abort  in  1  return to IDLE next cycle from any state.
- blockHeader  out  640  header to miner, stable during a sweep.
- nonce  out  32  current nonce to miner.
- minerReset  out  1  one-cycle restart pulse to miner.
- hashSuccess  in  1  miner success flag.
- satisfactoryHash  in  256  miner hash, valid while hashSuccess.
- result_valid  out  1  result held until accepted.
- result_ready  in  1  host accepts result.
- result_nonce  out  32  winning nonce.
- result_hash  out  256  winning hash.
- busy  out  1  high in KICK/WAIT.
- exhausted  out  1  range swept with no hit.

## Operation
- States: IDLE, KICK, WAIT, REPORT, EXHAUST.
- IDLE: wr_ready=1. Word k (0..19) loads blockHeader[639-32k -: 32]. Word 20 loads end_nonce. The word counter saturates at 21, and further writes overwrite end_nonce. loaded=1 once 21 words are received.
- IDLE & start & loaded → KICK, nonce ← blockHeader[31:0]. Start without loaded is ignored.
- KICK: minerReset=1 for exactly one cycle, attempt counter ← 0 → WAIT.
- WAIT: counter increments each cycle.
  - hashSuccess=1 → capture nonce and satisfactoryHash → REPORT.
  - Counter == ATTEMPT_CYCLES with no hit:
    - If nonce == end_nonce → EXHAUST.
    - Else nonce ← nonce+1 (mod 2^32; 0xFFFFFFFF wraps to 0x00000000) → KICK.
- Success seen on the same cycle the counter reaches ATTEMPT_CYCLES: success wins.
- REPORT: result_valid=1 and result_* held stable until result_ready. On handshake → IDLE.
- EXHAUST: exhausted=1 until abort or start. start re-sweeps from the header nonce.
- abort: next state IDLE, result_valid and exhausted cleared, header/end_nonce/loaded retained. abort on the same cycle as the result handshake: abort wins and the result is dropped.
- wr_ready=0 outside IDLE. Writes outside IDLE are ignored.

## Timing
- Reset values: all outputs 0, including blockHeader, nonce, minerReset, wr_ready, result_*, busy and exhausted. Internally the word counter is 0 and loaded=0. The first cycle after reset is IDLE, with wr_ready=1.
- start sampled at cycle t → minerReset high at t+1.
- Attempt period = ATTEMPT_CYCLES+1 cycles (KICK plus WAIT).
- nonce changes on the same edge that enters KICK, so it is stable during the minerReset pulse and the whole attempt.
- Capture to result_valid: 1 cycle.
- Handshake → IDLE or KICK on the next edge.

## Configuration
- SCAN_RESUME_EN defined: after the REPORT handshake, the sweep continues.
  - If nonce != end_nonce: nonce+1 → KICK.
  - Else → EXHAUST.
- SCAN_RESUME_EN undefined: after the REPORT handshake → IDLE; the sweep stops at the first hit.

## Test plan
- Load 21 words (header nonce field 0x00000010, end 0x00000012), start, hashSuccess never asserted:
  - Three minerReset pulses spaced 199 cycles apart.
  - nonce sequence 0x10, 0x11, 0x12.
  - exhausted=1 after the third attempt.
- Same load, hashSuccess=1 with hash 0xABCD… at cycle 150 of the second attempt:
  - result_valid with result_nonce=0x11 and result_hash=0xABCD….
  - Result held while result_ready=0 for 5 cycles.
  - After the handshake: IDLE (resume off), or KICK with nonce=0x12 (SCAN_RESUME_EN).
- Header nonce 0xFFFFFFFF, end 0x00000000, no hit: nonce wraps to 0x00000000 on the second attempt, then exhausted=1.
- hashSuccess asserted on exactly cycle ATTEMPT_CYCLES of an attempt: result captured for the current nonce, no increment.
- start with only 19 words loaded: no minerReset. abort mid-WAIT: IDLE next cycle with busy=0. Synchronous reset mid-WAIT: all outputs 0 and loaded=0.

Source files
------------

// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher: loads a 640-bit header and end nonce from the host, sweeps nonces through the miner, reports the first hit.
// SCAN_RESUME_EN: when defined, the sweep continues past an accepted result instead of returning to IDLE.
module nonce_dispatcher #(
  parameter int ATTEMPT_CYCLES = 198
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_valid,
  input  logic [31:0]  wr_data,
  output logic         wr_ready,
  input  logic         start,
  input  logic         abort,
  output logic [639:0] blockHeader,
  output logic [31:0]  nonce,
  output logic         minerReset,
  input  logic         hashSuccess,
  input  logic [255:0] satisfactoryHash,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [31:0]  result_nonce,
  output logic [255:0] result_hash,
  output logic         busy,
  output logic         exhausted
);
  localparam int CW = $clog2(ATTEMPT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, KICK, WAIT, REPORT, EXHAUST} state_t;
  state_t state, state_nxt;
  logic [4:0] wcnt;
  logic [31:0] end_nonce;
  logic [CW-1:0] cnt;
  logic loaded, last, done, first, step, capture;
  assign loaded = wcnt == 5'd21;
  assign last = nonce == end_nonce;
  // the attempt ends on the cycle whose increment would reach ATTEMPT_CYCLES, giving exactly that many WAIT cycles
  assign done = cnt == CW'(ATTEMPT_CYCLES - 1);
  assign wr_ready = state == IDLE && !reset;
  assign minerReset = state == KICK;
  assign busy = state == KICK || state == WAIT;
  assign result_valid = state == REPORT;
  assign exhausted = state == EXHAUST;
  always_comb begin
    state_nxt = state;
    first = 1'b0;
    step = 1'b0;
    capture = 1'b0;
    if (abort) state_nxt = IDLE;
    else case (state)
      IDLE: if (start && loaded) begin
        state_nxt = KICK;
        first = 1'b1;
      end
      KICK: state_nxt = WAIT;
      WAIT: if (hashSuccess) begin
        state_nxt = REPORT;
        capture = 1'b1;
      end else if (done) begin
        state_nxt = last ? EXHAUST : KICK;
        step = !last;
      end
`ifdef SCAN_RESUME_EN
      REPORT: if (result_ready) begin
        state_nxt = last ? EXHAUST : KICK;
        step = !last;
      end
`else
      REPORT: if (result_ready) state_nxt = IDLE;
`endif
      EXHAUST: if (start) begin
        state_nxt = KICK;
        first = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      wcnt <= '0;
      end_nonce <= '0;
      blockHeader <= '0;
      nonce <= '0;
      cnt <= '0;
      result_nonce <= '0;
      result_hash <= '0;
    end else begin
      state <= state_nxt;
      if (wr_valid && wr_ready) begin
        if (wcnt < 5'd20) blockHeader[10'd639 - {wcnt, 5'd0} -: 32] <= wr_data;
        else end_nonce <= wr_data;
        if (!loaded) wcnt <= wcnt + 5'd1;
      end
      if (first) nonce <= blockHeader[31:0];
      else if (step) nonce <= nonce + 32'd1;
      cnt <= state == KICK ? '0 : cnt + CW'(1);
      if (capture) begin
        result_nonce <= nonce;
        result_hash <= satisfactoryHash;
      end
    end
  end
endmodule

// File: tb/tb_nonce_dispatcher.sv
// tb_nonce_dispatcher: directed and randomized sweeps checked against an arithmetic model of attempt timing and nonce order.
module tb_nonce_dispatcher;
  localparam int AC = 198;
  localparam int PER = AC + 1;
  logic clock = 1'b0, reset = 1'b1, wr_valid = 1'b0, start = 1'b0, abort = 1'b0;
  logic hashSuccess = 1'b0, result_ready = 1'b0;
  logic [31:0] wr_data = '0;
  logic [255:0] satisfactoryHash = '0;
  logic wr_ready, minerReset, result_valid, busy, exhausted;
  logic [639:0] blockHeader;
  logic [31:0] nonce, result_nonce;
  logic [255:0] result_hash;
  logic [639:0] hdr_model;
  int cyc = 0, errors = 0, checks = 0;

  nonce_dispatcher #(.ATTEMPT_CYCLES(AC)) dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .abort(abort), .blockHeader(blockHeader), .nonce(nonce), .minerReset(minerReset),
    .hashSuccess(hashSuccess), .satisfactoryHash(satisfactoryHash), .result_valid(result_valid),
    .result_ready(result_ready), .result_nonce(result_nonce), .result_hash(result_hash),
    .busy(busy), .exhausted(exhausted)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reset, then write the header words (word 19 is the nonce field) and optionally an extra end-nonce overwrite
  task automatic load(input logic [31:0] n0, input logic [31:0] ne, input int words, input bit extra);
    logic [31:0] w;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    hdr_model = '0;
    for (int k = 0; k < words; k++) begin
      w = k == 19 ? n0 : k == 20 ? (extra ? $urandom : ne) : $urandom;
      if (k < 20) hdr_model[639 - 32*k -: 32] = w;
      wr_valid = 1'b1;
      wr_data = w;
      tick;
    end
    if (extra) begin
      wr_data = ne;
      tick;
    end
    wr_valid = 1'b0;
  endtask

  task automatic sweep(input string tag, input logic [31:0] n0, input logic [31:0] ne,
                       input int hit_att, input int hit_c, input bit extra);
    logic [31:0] d, en;
    logic [255:0] h;
    int n, s, t_end, t_obs;
    bit fin;
    int pc[$];
    logic [31:0] pn[$];
    load(n0, ne, 21, extra);
    check({tag, "_hdr"}, blockHeader, hdr_model);
    d = ne - n0;
    n = hit_att >= 0 ? hit_att + 1 : int'(d) + 1;
    for (int j = 0; j < 8; j++) h[32*j +: 32] = $urandom;
    h[255:240] = 16'hABCD;
    start = 1'b1;
    s = cyc;
    tick;
    start = 1'b0;
    t_end = hit_att >= 0 ? s + 1 + PER*hit_att + hit_c + 1 : s + 1 + PER*n;
    fin = 1'b0;
    t_obs = -1;
    for (int i = 0; i < PER*n + 10 && !fin; i++) begin
      if (minerReset) begin
        pc.push_back(cyc);
        pn.push_back(nonce);
      end
      if (result_valid || exhausted) begin
        fin = 1'b1;
        t_obs = cyc;
      end else begin
        hashSuccess = hit_att >= 0 && cyc == s + 1 + PER*hit_att + hit_c;
        satisfactoryHash = hashSuccess ? h : ~h;
        tick;
      end
    end
    hashSuccess = 1'b0;
    check({tag, "_end_cycle"}, t_obs, t_end);
    check({tag, "_pulses"}, pc.size(), n);
    foreach (pc[i]) begin
      en = n0 + i;
      check($sformatf("%s_pulse%0d_cycle", tag, i), pc[i], s + 1 + PER*i);
      check($sformatf("%s_pulse%0d_nonce", tag, i), pn[i], en);
    end
    check({tag, "_busy"}, busy, 0);
    if (hit_att >= 0) begin
      en = n0 + hit_att;
      check({tag, "_result_valid"}, result_valid, 1);
      check({tag, "_result_nonce"}, result_nonce, en);
      check({tag, "_result_hash"}, result_hash, h);
      check({tag, "_not_exhausted"}, exhausted, 0);
    end else begin
      check({tag, "_exhausted"}, exhausted, 1);
      check({tag, "_no_result"}, result_valid, 0);
    end
  endtask

  initial begin
    logic [31:0] rn0, rne;
    int ratt;
    tick;
    tick;
    check("rst_wr_ready", wr_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_exhausted", exhausted, 0);
    check("rst_minerReset", minerReset, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_nonce", nonce, 0);
    check("rst_header", blockHeader, 0);
    check("rst_result", {result_nonce, result_hash}, 0);
    reset = 1'b0;
    tick;
    check("idle_wr_ready", wr_ready, 1);

    sweep("nohit", 32'h10, 32'h12, -1, 0, 1'b0);
    tick;
    tick;
    check("exhaust_held", exhausted, 1);
    check("exhaust_wr_ready", wr_ready, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("resweep_pulse", minerReset, 1);
    check("resweep_nonce", nonce, 32'h10);
    check("resweep_exhausted", exhausted, 0);
    for (int i = 0; i < 50; i++) tick;
    check("mid_wait_busy", busy, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_wr_ready", wr_ready, 1);
    check("abort_minerReset", minerReset, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("retained_pulse", minerReset, 1);
    check("retained_nonce", nonce, 32'h10);
    for (int i = 0; i < 30; i++) tick;
    reset = 1'b1;
    tick;
    check("midrst_outputs", {busy, exhausted, minerReset, result_valid, wr_ready}, 0);
    check("midrst_nonce", nonce, 0);
    check("midrst_header", blockHeader, 0);
    reset = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("midrst_unloaded", {minerReset, busy}, 0);
      tick;
    end

    sweep("hit", 32'h10, 32'h12, 1, 150, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("hold_valid", result_valid, 1);
      check("hold_data", {result_nonce, result_hash[255:240]}, {32'h11, 16'hABCD});
    end
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
    check("ack_result_valid", result_valid, 0);
`ifdef SCAN_RESUME_EN
    check("ack_resume_pulse", minerReset, 1);
    check("ack_resume_nonce", nonce, 32'h12);
`else
    check("ack_idle", {busy, minerReset, wr_ready}, 3'b001);
`endif

    load(32'h5, 32'h7, 19, 1'b0);
    check("part_header", blockHeader, hdr_model);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("part_no_kick", {minerReset, busy}, 0);
      tick;
    end

    sweep("wrap", 32'hFFFF_FFFF, 32'h0, -1, 0, 1'b0);
    sweep("edge", 32'h20, 32'h22, 0, AC, 1'b0);
    sweep("first", 32'h40, 32'h41, 0, 1, 1'b1);
    result_ready = 1'b1;
    abort = 1'b1;
    tick;
    result_ready = 1'b0;
    abort = 1'b0;
    check("ack_abort", {result_valid, busy, minerReset, wr_ready}, 4'b0001);

    for (int r = 0; r < 3; r++) begin
      rn0 = $urandom;
      rne = rn0 + 32'($urandom_range(0, 2));
      ratt = $urandom_range(0, int'(rne - rn0) + 1) - 1;
      sweep($sformatf("rand%0d", r), rn0, rne, ratt, $urandom_range(1, AC), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
